sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Round-robin arbiter that shares one `sram_controller` host port among `NUM_REQ` requesters. It captures one requester's transaction, issues it to the controller as a single-cycle `read_req` or `write_req`, and waits for `ready`. It then returns read data and a completion pulse to the owner. It sits between the lab's bus masters (DMA, CPU-side test driver) and the SRAM controller.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 15: address width; matches the controller.
- `DATA_W`, 16: data width; matches the controller.
- `TIMEOUT_CYCLES`, 16: WAIT watchdog limit; used only with `SRAM_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i is slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `req_gnt`  out  NUM_REQ  one-hot owner; high from ISSUE through RESP.
- `req_done`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `req_err`  out  1  qualifies `req_done`: timeout abort.
- `rsp_rdata`  out  DATA_W  read data; valid while `req_done` is high.
- `busy`  out  1  state != IDLE.
- `mem_read_req`, `mem_write_req`  out  1  to the controller.
- `mem_addr`  out  ADDR_W  to the controller.
- `mem_wdata`  out  DATA_W  to the controller.
- `mem_rdata`  in  DATA_W  from the controller.
- `mem_ready`  in  1  from the controller.

## Operation
- Four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any `req_valid` is high, pick the winner by round-robin and go to ISSUE. On that edge, register the one-hot grant and capture the winner's `we`, `addr` and `wdata`.
- **Round-robin:** pointer `ptr` resets to 0. The winner is the lowest index at or after `ptr`, wrapping modulo `NUM_REQ`. When requester w is granted, `ptr` becomes (w+1) mod `NUM_REQ`.
- **ISSUE:** lasts exactly 1 cycle.
  - Assert `mem_write_req` if the captured `we` = 1, else `mem_read_req`; never both.
  - `mem_addr` and `mem_wdata` come from the captured registers.
  - Next state is WAIT.
- **WAIT:**
  - Both request lines low.
  - `mem_addr` and `mem_wdata` stay held.
  - When `mem_ready` is sampled high, capture `mem_rdata` into the `rsp_rdata` register and go to RESP.
- **RESP:**
  - Assert `req_done[owner]` for 1 cycle; `req_gnt` is still held.
  - Next state is IDLE; the grant clears on that edge.
- **Requester protocol:**
  - Hold `req_valid`, `req_we`, `req_addr` and `req_wdata` until the grant is seen. Attributes are captured at grant, so later changes are ignored.
  - Drop `req_valid` on the edge that samples `req_done`, or keep it high to request again.
  - If a requester drops `req_valid` while granted, the transaction still completes.
- `mem_ready` is ignored in IDLE, ISSUE and RESP.
- `rsp_rdata` is loaded on writes too, with don't-care content.
- Requesters that are not granted never see `req_done` or `req_gnt`.

## Timing
- **Reset values:** all outputs 0, `ptr` = 0, state IDLE. Reset asserted mid-transaction aborts immediately with no `req_done`. The controller is reset by the same `rst_n`.
- **Latency with the standard controller** (READ→DONE): edges counted from the first edge sampling `req_valid` as E0.
  - E0: enter ISSUE.
  - E1: enter WAIT; controller enters READ/WRITE.
  - E2: controller enters DONE and raises `mem_ready`.
  - E3: enter RESP; `req_done` is high in the following cycle.
  - E4: enter IDLE.
- Request to `req_done` is 4 cycles. The next grant is sampled at E5, so throughput is 1 transaction per 5 cycles.
- Simultaneous requests: exactly one grant per transaction, by the round-robin pointer.

## Configuration
- Macro: `SRAM_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `mem_ready`, go to RESP with `req_err` = 1 and `rsp_rdata` = 0.
  - If `mem_ready` arrives in the same cycle as the limit, `mem_ready` wins and `req_err` = 0.
- **Undefined:** WAIT lasts indefinitely; `req_err` is tied to 0; no counter is built.

## Test plan
- Reset, then requester 0 writes 0x1234 to addr 0x0005 → `mem_write_req` high for 1 cycle with `mem_addr` = 0x0005 and `mem_wdata` = 0x1234; `req_done[0]` 4 cycles after the request edge.
- Requester 1 reads addr 0x0005 with the SRAM model returning 0x1234 → `rsp_rdata` = 0x1234 during `req_done[1]`; `mem_read_req` pulses for exactly 1 cycle.
- All 4 requesters held valid for 8 transactions → grant order 0,1,2,3,0,1,2,3; never 2 grant bits set; 1 transaction per 5 cycles.
- Requester 2 changes `req_addr` from 0x0010 to 0x7FFF after the grant → `mem_addr` stays 0x0010 through WAIT.
- `rst_n` pulsed low during WAIT → all outputs 0 on the same cycle; no `req_done`; the next request after reset is granted by `ptr` = 0.
- With `SRAM_ARB_TIMEOUT_EN` and `mem_ready` stuck low → `req_done` with `req_err` = 1 and `rsp_rdata` = 0 after 16 WAIT cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one SRAM controller host port among
// NUM_REQ requesters. Each transaction runs IDLE -> ISSUE -> WAIT -> RESP.
// Optional WAIT watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.

module sram_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_gnt_o,
    output logic [NUM_REQ-1:0]        req_done_o,
    output logic                      req_err_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      busy_o,
    output logic                      mem_read_req_o,
    output logic                      mem_write_req_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      mem_ready_i
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               win_found;
    logic [PtrW-1:0]    win_idx;
    logic [PtrW-1:0]    ptr_next;
    logic [NUM_REQ-1:0] win_onehot;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Round-robin pick: lowest requesting index at or after ptr_q, wrapping.
    always_comb begin : p_arb
        int unsigned idx;
        logic [PtrW-1:0] idx_w;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx   = (32'(ptr_q) + k) % NUM_REQ;
            idx_w = PtrW'(idx);
            if (!win_found && req_valid_i[idx_w]) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    // Pointer advance and one-hot grant for the current winner.
    always_comb begin
        ptr_next   = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    end

    // Next-state logic for the transaction FSM and captured attributes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StIssue;
                    gnt_d   = win_onehot;
                    ptr_d   = ptr_next;
                    // Attributes are frozen here; later requester changes are ignored.
                    we_d    = req_we_i[win_idx];
                    addr_d  = req_addr_i[32'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata_i[32'(win_idx)*DATA_W +: DATA_W];
`ifdef SRAM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef SRAM_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                // mem_ready takes priority over a watchdog expiry in the same cycle.
                if (mem_ready_i) begin
                    state_d = StResp;
                    rdata_d = mem_rdata_i;
`ifdef SRAM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            StResp: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    // Watchdog counter and abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    // Outputs decoded from state and captured registers.
    always_comb begin
        req_gnt_o       = gnt_q;
        req_done_o      = (state_q == StResp) ? gnt_q : '0;
        busy_o          = (state_q != StIdle);
        mem_read_req_o  = (state_q == StIssue) && !we_q;
        mem_write_req_o = (state_q == StIssue) && we_q;
        mem_addr_o      = addr_q;
        mem_wdata_o     = wdata_q;
        rsp_rdata_o     = rdata_q;
`ifdef SRAM_ARB_TIMEOUT_EN
        req_err_o       = (state_q == StResp) && err_q;
`else
        req_err_o       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed transactions, scoreboard of
// expected completions, and a simple SRAM controller model (READ/WRITE -> DONE).

module tb_sram_arbiter;

    localparam int NR = 4;
    localparam int AW = 15;
    localparam int DW = 16;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_we;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR-1:0]      req_gnt;
    logic [NR-1:0]      req_done;
    logic               req_err;
    logic [DW-1:0]      rsp_rdata;
    logic               busy;
    logic               mem_read_req;
    logic               mem_write_req;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               mem_ready;

    int n_vec;
    int n_err;

    typedef struct {
        int          idx;
        logic        err;
        logic        chk;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];

    sram_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_we_i        (req_we),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_gnt_o       (req_gnt),
        .req_done_o      (req_done),
        .req_err_o       (req_err),
        .rsp_rdata_o     (rsp_rdata),
        .busy_o          (busy),
        .mem_read_req_o  (mem_read_req),
        .mem_write_req_o (mem_write_req),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (mem_rdata),
        .mem_ready_i     (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM controller model: request sampled -> READ/WRITE, next edge -> DONE/ready.
    logic [15:0] mem_arr [0:255];
    logic        pend_q;
    logic        stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= 16'h0;
        end else begin
            pend_q    <= mem_read_req | mem_write_req;
            mem_ready <= pend_q && !stall;
            if (mem_write_req) mem_arr[mem_addr[7:0]] <= mem_wdata;
            if (pend_q) mem_rdata <= stall ? 16'hDEAD : mem_arr[mem_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("gnt_onehot0", 64'($onehot0(req_gnt)), 64'd1);
            chk("no_dual_req", 64'(mem_read_req & mem_write_req), 64'd0);
            if (req_done != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(req_done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_owner", 64'(req_done), 64'(4'b0001 << e.idx));
                    chk("gnt_during_done", 64'(req_gnt), 64'(req_done));
                    chk("done_err", 64'(req_err), 64'(e.err));
                    if (e.chk) chk("done_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
            end
        end
    end

    task automatic txn(input int idx, input logic we, input logic [14:0] addr,
                       input logic [15:0] wdata, input logic chk_rd, input logic [15:0] exp_rd,
                       input logic exp_err, input int exp_lat, input logic chg_addr);
        int cyc;
        int pulses;
        bit got;
        @(negedge clk);
        req_valid[idx]            = 1'b1;
        req_we[idx]               = we;
        req_addr[idx*AW +: AW]    = addr;
        req_wdata[idx*DW +: DW]   = wdata;
        sb.push_back('{idx, exp_err, chk_rd, exp_rd});
        cyc = 0;
        pulses = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_read_req || mem_write_req) begin
                pulses++;
                chk("issue_type", 64'(mem_write_req), 64'(we));
            end
            if (busy && req_done == '0) begin
                chk("mem_addr_held", 64'(mem_addr), 64'(addr));
                if (we) chk("mem_wdata_held", 64'(mem_wdata), 64'(wdata));
            end
            if (req_gnt[idx]) begin
                req_valid[idx] = 1'b0;
                if (chg_addr) req_addr[idx*AW +: AW] = 15'h7FFF;
            end
            if (req_done != '0) got = 1;
        end
        chk("done_latency", 64'(cyc), 64'(exp_lat));
        chk("req_pulse_count", 64'(pulses), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc;
        int last;
        int n_done;
        n_vec     = 0;
        n_err     = 0;
        stall     = 1'b0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {req_gnt, req_done, req_err, rsp_rdata, busy, mem_read_req,
                              mem_write_req, mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;

        // Write 0x1234 to 0x0005 via requester 0, then read it back via requester 1.
        txn(0, 1'b1, 15'h0005, 16'h1234, 1'b0, 16'h0, 1'b0, 4, 1'b0);
        txn(1, 1'b0, 15'h0005, 16'h0000, 1'b1, 16'h1234, 1'b0, 4, 1'b0);
        // Requester 2 changes its address after grant; captured 0x0010 must persist.
        txn(2, 1'b1, 15'h0010, 16'hBEEF, 1'b0, 16'h0, 1'b0, 4, 1'b1);
        txn(0, 1'b0, 15'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 4, 1'b0);

        // Reset during WAIT of a requester-1 read: immediate abort, no completion.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1] = 1'b0;
        req_addr[1*AW +: AW] = 15'h0005;
        repeat (2) begin
            @(negedge clk);
            if (req_gnt[1]) req_valid[1] = 1'b0;
        end
        chk("in_wait_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", {req_gnt, req_done, req_err, rsp_rdata, busy, mem_read_req,
                                  mem_write_req, mem_addr, mem_wdata}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_abort", 64'(req_done), 64'd0);
        end

        // All four requesters held valid: grants 0,1,2,3,0,1,2,3 at 5 cycles each.
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = 1'b1;
            req_we[i] = 1'b1;
            req_addr[i*AW +: AW] = 15'(32'h20 + i);
            req_wdata[i*DW +: DW] = 16'(32'hA000 + i);
        end
        for (int k = 0; k < 8; k++) sb.push_back('{k % NR, 1'b0, 1'b0, 16'h0});
        cyc = 0;
        last = 0;
        n_done = 0;
        while (n_done < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req_done != '0) begin
                n_done++;
                if (n_done == 1) chk("rr_first_latency", 64'(cyc), 64'd4);
                else chk("rr_interval", 64'(cyc - last), 64'd5);
                last = cyc;
                if (n_done == 8) req_valid = '0;
            end
        end
        chk("rr_done_count", 64'(n_done), 64'd8);
        repeat (3) @(negedge clk);
        chk("rr_idle_after", 64'(busy), 64'd0);

        // Read back a round-robin write via requester 3.
        txn(3, 1'b0, 15'h0023, 16'h0000, 1'b1, 16'hA003, 1'b0, 4, 1'b0);

`ifdef SRAM_ARB_TIMEOUT_EN
        // Controller never answers: abort after 16 WAIT cycles with err and zero data.
        stall = 1'b1;
        txn(0, 1'b0, 15'h0005, 16'h0000, 1'b1, 16'h0000, 1'b1, 18, 1'b0);
        stall = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
